// File: rtl/lieat_sram_fifo_pkg.sv
// Shared sizing and action encoding for the SRAM-backed FIFO controller.
// The width constants are common with the lieat_general_64x64_sram instance beside it.
package lieat_sram_fifo_pkg;

    localparam int LIEAT_FIFO_DW = 64;
    localparam int LIEAT_FIFO_AW = 6;

    // One action owns the single SRAM port each cycle, in priority order.
    typedef enum logic [1:0] {
        ACT_FLUSH  = 2'd0,
        ACT_REFILL = 2'd1,
        ACT_BYPASS = 2'd2,
        ACT_WRITE  = 2'd3
    } fifo_act_e;

endpackage

// File: rtl/lieat_sram_fifo.sv
// 64x64 FIFO controller driving the single-port SRAM, with a one-entry head register
// that provides registered out_data and one extra entry of capacity.
module lieat_sram_fifo
    import lieat_sram_fifo_pkg::*;
#(
    parameter int DW = LIEAT_FIFO_DW,
    parameter int AW = LIEAT_FIFO_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   count,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    input  logic [DW-1:0] sram_q
);

    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   sram_cnt_q, sram_cnt_d;
    logic          head_vld_q, head_vld_d;
    logic [DW-1:0] head_data_q, head_data_d;

    fifo_act_e     act_s;
    logic          head_free_s;
    logic          sram_empty_s;
    logic          sram_space_s;

    // Pick the single action for this cycle.
    always_comb begin
        head_free_s  = !head_vld_q || out_ready;
        sram_empty_s = (sram_cnt_q == CNT_ZERO);
        sram_space_s = (sram_cnt_q < CNT_FULL);
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (!sram_empty_s && head_free_s) begin
            act_s = ACT_REFILL;
        end else if (head_free_s) begin
            act_s = ACT_BYPASS;
        end else begin
            act_s = ACT_WRITE;
        end
    end

    // Next state and SRAM port drive for the chosen action.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sram_cnt_d  = sram_cnt_q;
        head_vld_d  = head_vld_q;
        head_data_d = head_data_q;
        in_ready    = 1'b0;
        sram_cen    = 1'b1;
        sram_wen    = 1'b0;
        sram_a      = rd_ptr_q;
        case (act_s)
            ACT_FLUSH: begin
                wr_ptr_d   = PTR_ZERO;
                rd_ptr_d   = PTR_ZERO;
                sram_cnt_d = CNT_ZERO;
                head_vld_d = 1'b0;
            end
            ACT_REFILL: begin
                sram_cen    = 1'b0;
                head_data_d = sram_q;
                head_vld_d  = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                sram_cnt_d  = sram_cnt_q - CNT_ONE;
            end
            ACT_BYPASS: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    head_data_d = in_data;
                    head_vld_d  = 1'b1;
                end else begin
                    // Head is either already empty or being popped.
                    head_vld_d = 1'b0;
                end
            end
            ACT_WRITE: begin
                in_ready = sram_space_s;
                if (in_valid && sram_space_s) begin
                    sram_cen   = 1'b0;
                    sram_wen   = 1'b1;
                    sram_a     = wr_ptr_q;
                    wr_ptr_d   = wr_ptr_q + PTR_ONE;
                    sram_cnt_d = sram_cnt_q + CNT_ONE;
                end else begin
                    wr_ptr_d   = wr_ptr_q;
                    sram_cnt_d = sram_cnt_q;
                end
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
            end
        endcase
    end

    // State registers; SRAM contents are never scrubbed on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            sram_cnt_q  <= CNT_ZERO;
            head_vld_q  <= 1'b0;
            head_data_q <= {DW{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sram_cnt_q  <= sram_cnt_d;
            head_vld_q  <= head_vld_d;
            head_data_q <= head_data_d;
        end
    end

    assign sram_d    = in_data;
    assign out_valid = head_vld_q;
    assign out_data  = head_data_q;
    assign count     = sram_cnt_q + {{AW{1'b0}}, head_vld_q};

endmodule

// File: tb/tb_lieat_sram_fifo.sv
// Directed bench for lieat_sram_fifo with a behavioural combinational-read SRAM beside it.
module tb_lieat_sram_fifo;

    localparam int DW = 64;
    localparam int AW = 6;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [0:63];

    int vectors     = 0;
    int miscompares = 0;

    lieat_sram_fifo #(.DW(DW), .AW(AW)) dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .sram_cen (sram_cen),
        .sram_wen (sram_wen),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!sram_cen && sram_wen) mem[sram_a] <= sram_d;
    end
    assign sram_q = mem[sram_a];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 64'd0;
        #3 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || count !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got vld=%0b data=%h cnt=%0d want 0/0/0", out_valid, out_data, count);
        end
        vectors++;
        if (sram_cen !== 1'b1 || sram_wen !== 1'b0 || sram_a !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_sram: got cen=%0b wen=%0b a=%0d want 1/0/0", sram_cen, sram_wen, sram_a);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_bypass;
        in_valid = 1'b1; in_data = 64'hA5A5_0000_0000_0001; out_ready = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_port: got rdy=%0b cen=%0b want 1/1", in_ready, sram_cen);
        end
        tick;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'hA5A5_0000_0000_0001 || count !== 7'd1) begin
            miscompares++;
            $display("FAIL bypass_head: got vld=%0b data=%h cnt=%0d want 1/a5a5000000000001/1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || count !== 7'd0) begin
            miscompares++;
            $display("FAIL bypass_pop: got vld=%0b cnt=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < 65; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h0F00_0000_0000_0000 | 64'(i);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got %0b want 1", i, in_ready);
            end
            if (i > 0) begin
                vectors++;
                if (sram_cen !== 1'b0 || sram_wen !== 1'b1 || sram_a !== 6'(i - 1)) begin
                    miscompares++;
                    $display("FAIL fill_write[%0d]: got cen=%0b wen=%0b a=%0d want 0/1/%0d", i, sram_cen, sram_wen, sram_a, i - 1);
                end
            end
            tick;
        end
        in_valid = 1'b1;
        #1;
        vectors++;
        if (count !== 7'd65 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: got cnt=%0d rdy=%0b want 65/0", count, in_ready);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b0 || sram_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL full_pop_ready: got rdy=%0b cen=%0b wen=%0b want 0/0/0", in_ready, sram_cen, sram_wen);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_drain;
        out_ready = 1'b1;
        for (int k = 0; k < 65; k++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b1 || out_data !== (64'h0F00_0000_0000_0000 | 64'(k))) begin
                miscompares++;
                $display("FAIL drain_data[%0d]: got vld=%0b data=%h want 1/%h", k, out_valid, out_data, 64'h0F00_0000_0000_0000 | 64'(k));
            end
            vectors++;
            if (k < 64) begin
                if (sram_cen !== 1'b0 || sram_wen !== 1'b0 || sram_a !== 6'(k) || in_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL drain_read[%0d]: got cen=%0b wen=%0b a=%0d rdy=%0b want 0/0/%0d/0", k, sram_cen, sram_wen, sram_a, in_ready, k);
                end
            end else begin
                if (sram_cen !== 1'b1 || in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL drain_last: got cen=%0b rdy=%0b want 1/1", sram_cen, in_ready);
                end
            end
            tick;
        end
        out_ready = 1'b0;
        vectors++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got cnt=%0d vld=%0b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] sb[$];
        logic [DW-1:0] nxt;
        logic          acc;
        logic          pop;
        int            done;
        int            cyc;
        nxt = 64'h5A00_0000_0000_0000;
        for (int ph = 0; ph < 4; ph++) begin
            done = 0;
            cyc  = 0;
            while (done < 40 && cyc < 2000) begin
                if (ph % 2 == 0) begin
                    in_valid  = 1'($urandom_range(0, 1));
                    out_ready = 1'b0;
                end else begin
                    in_valid  = 1'b0;
                    out_ready = 1'($urandom_range(0, 1));
                end
                in_data = nxt;
                #1;
                acc = in_valid & in_ready;
                pop = out_valid & out_ready;
                if (pop) begin
                    vectors++;
                    if (out_data !== sb[0]) begin
                        miscompares++;
                        $display("FAIL wrap_data[ph%0d]: got %h want %h", ph, out_data, sb[0]);
                    end
                    void'(sb.pop_front());
                    done++;
                end
                if (acc) begin
                    sb.push_back(nxt);
                    nxt = nxt + 64'd1;
                    done++;
                end
                tick;
                cyc++;
                vectors++;
                if (count !== 7'(sb.size())) begin
                    miscompares++;
                    $display("FAIL wrap_count[ph%0d]: got %0d want %0d", ph, count, sb.size());
                end
            end
            vectors++;
            if (done != 40) begin
                miscompares++;
                $display("FAIL wrap_timeout[ph%0d]: got %0d transfers want 40", ph, done);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h1111_0000_0000_0000 + 64'(i);
            tick;
        end
        in_valid = 1'b0;
        vectors++;
        if (count !== 7'd10) begin
            miscompares++;
            $display("FAIL flush_pre: got cnt=%0d want 10", count);
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || sram_cen !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_port: got rdy=%0b cen=%0b want 0/1", in_ready, sram_cen);
        end
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: got cnt=%0d vld=%0b want 0/0", count, out_valid);
        end
        in_valid = 1'b1; in_data = 64'h0000_0000_0000_0077;
        tick;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_0000_0077 || count !== 7'd1) begin
            miscompares++;
            $display("FAIL flush_after: got vld=%0b data=%h cnt=%0d want 1/77/1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        vectors++;
        if (count !== 7'd0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drain: got cnt=%0d vld=%0b want 0/0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h3300_0000_0000_0000 + 64'(i);
            tick;
        end
        in_valid = 1'b0;
        vectors++;
        if (count !== 7'd30) begin
            miscompares++;
            $display("FAIL rstmid_pre: got cnt=%0d want 30", count);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || count !== 7'd0 || sram_cen !== 1'b1 || sram_a !== 6'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_async: got vld=%0b data=%h cnt=%0d cen=%0b a=%0d rdy=%0b want 0/0/0/1/0/1",
                     out_valid, out_data, count, sram_cen, sram_a, in_ready);
        end
        tick;
        reset = 1'b1;
        in_valid = 1'b1; in_data = 64'h00C0_FFEE_0000_0001;
        tick;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 64'h00C0_FFEE_0000_0001 || count !== 7'd1) begin
            miscompares++;
            $display("FAIL rstmid_bypass: got vld=%0b data=%h cnt=%0d want 1/00c0ffee00000001/1", out_valid, out_data, count);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
